// File: rtl/ssf_in_feeder_if.sv
// ssf_in_feeder host/processor bus bundle.
// Two sample sources, processor request/data, and host status.
interface ssf_in_feeder_if #(
    parameter int NUBITS = 32,
    parameter int AW     = 3
);
    logic [NUBITS-1:0] s0_data;
    logic              s0_valid;
    logic              s0_ready;
    logic [NUBITS-1:0] s1_data;
    logic              s1_valid;
    logic              s1_ready;
    logic [1:0]        req_in;
    logic [NUBITS-1:0] io_in;
    logic [AW:0]       level0;
    logic [AW:0]       level1;
    logic              clr_flags;
    logic [1:0]        underflow;
    logic              req_err;

    modport master (
        output s0_data, s0_valid, s1_data, s1_valid,
        output req_in, clr_flags,
        input  s0_ready, s1_ready, io_in,
        input  level0, level1, underflow, req_err
    );

    modport slave (
        input  s0_data, s0_valid, s1_data, s1_valid,
        input  req_in, clr_flags,
        output s0_ready, s1_ready, io_in,
        output level0, level1, underflow, req_err
    );
endinterface

// File: rtl/ssf_in_feeder.sv
// Dual-channel input FIFO feeding the ssf processor io_in bus.
// Zero-latency read on req_in, hold register keeps the bus stable.
module ssf_in_feeder #(
    parameter int NUBITS = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    ssf_in_feeder_if.slave bus
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [NUBITS-1:0] s_data [2];
    logic [1:0]        s_valid;
    logic [1:0]        ready;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        empty;
    logic [AW:0]       level [2];
    logic [NUBITS-1:0] head [2];

    logic [1:0]        req;
    logic [1:0]        uf_set;
    logic              err_set;

    logic [NUBITS-1:0] io_d;
    logic [NUBITS-1:0] hold_q;
    logic [NUBITS-1:0] hold_d;
    logic [1:0]        underflow_q;
    logic [1:0]        underflow_d;
    logic              req_err_q;
    logic              req_err_d;

    assign s_data[0]  = bus.s0_data;
    assign s_data[1]  = bus.s1_data;
    assign s_valid[0] = bus.s0_valid;
    assign s_valid[1] = bus.s1_valid;
    assign req        = bus.req_in;

    // Channel 0 wins on an illegal two-hot request; channel 1 is left alone.
    always_comb begin
        empty[0]  = (level[0] == '0);
        empty[1]  = (level[1] == '0);
        pop[0]    = req[0] & ~empty[0];
        pop[1]    = req[1] & ~req[0] & ~empty[1];
        uf_set[0] = req[0] & empty[0];
        uf_set[1] = req[1] & ~req[0] & empty[1];
        err_set   = &req;
        push      = s_valid & ready;
    end

    for (genvar k = 0; k < 2; k++) begin : g_ch
        logic [NUBITS-1:0] mem_q [DEPTH];
        logic [AW-1:0]     wptr_q;
        logic [AW-1:0]     wptr_d;
        logic [AW-1:0]     rptr_q;
        logic [AW-1:0]     rptr_d;
        logic [AW:0]       level_q;
        logic [AW:0]       level_d;
        logic              ready_q;

        // Pointer and occupancy next state; push and pop may coincide.
        always_comb begin
            wptr_d  = wptr_q;
            rptr_d  = rptr_q;
            level_d = level_q;
            if (push[k]) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop[k]) begin
                rptr_d = rptr_q + AW'(1);
            end
            unique case ({push[k], pop[k]})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end

        // Sample storage; contents are don't-care until the level covers them.
        always_ff @(posedge clk) begin
            if (push[k]) begin
                mem_q[wptr_q] <= s_data[k];
            end
        end

        // Pointers, level and registered ready (no req_in to ready path).
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                level_q <= '0;
                ready_q <= 1'b0;
            end else begin
                wptr_q  <= wptr_d;
                rptr_q  <= rptr_d;
                level_q <= level_d;
                ready_q <= (level_d != FULL);
            end
        end

        assign level[k] = level_q;
        assign ready[k] = ready_q;
        assign head[k]  = mem_q[rptr_q];
    end

    // Bus mux: head of the popped channel, otherwise the last delivered sample.
    always_comb begin
        io_d = hold_q;
        unique case (1'b1)
            pop[0]:  io_d = head[0];
            pop[1]:  io_d = head[1];
            default: io_d = hold_q;
        endcase
    end

    // Sticky flag and hold next state; a set beats a clear on the same edge.
    always_comb begin
        hold_d      = (|pop) ? io_d : hold_q;
        underflow_d = uf_set | (underflow_q & {2{~bus.clr_flags}});
        req_err_d   = err_set | (req_err_q & ~bus.clr_flags);
    end

    // Hold register and sticky status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q      <= '0;
            underflow_q <= '0;
            req_err_q   <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            underflow_q <= underflow_d;
            req_err_q   <= req_err_d;
        end
    end

    assign bus.s0_ready  = ready[0];
    assign bus.s1_ready  = ready[1];
    assign bus.io_in     = io_d;
    assign bus.level0    = level[0];
    assign bus.level1    = level[1];
    assign bus.underflow = underflow_q;
    assign bus.req_err   = req_err_q;
endmodule

// File: tb/tb_ssf_in_feeder.sv
// Directed bench for ssf_in_feeder.
// Expected values are hand-computed from the behaviour description.
module tb_ssf_in_feeder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ssf_in_feeder_if #(.NUBITS(32), .AW(3)) bus ();

    ssf_in_feeder #(
        .NUBITS(32),
        .DEPTH (8),
        .AW    (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [31:0] v);
        bus.s0_data  = v;
        bus.s0_valid = 1'b1;
        tick();
        bus.s0_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] r, input logic [31:0] exp,
                      input string tag);
        bus.req_in = r;
        #1;
        chk(tag, bus.io_in, exp);
        tick();
        bus.req_in = 2'b00;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b0;
        bus.s0_data    = '0;
        bus.s0_valid   = 1'b0;
        bus.s1_data    = '0;
        bus.s1_valid   = 1'b0;
        bus.req_in     = 2'b00;
        bus.clr_flags  = 1'b0;

        repeat (3) tick();
        chk("rst_io", bus.io_in, 0);
        chk("rst_lv0", 32'(bus.level0), 0);
        chk("rst_lv1", 32'(bus.level1), 0);
        chk("rst_rdy0", 32'(bus.s0_ready), 0);
        chk("rst_rdy1", 32'(bus.s1_ready), 0);
        chk("rst_uf", 32'(bus.underflow), 0);
        chk("rst_err", 32'(bus.req_err), 0);
        rst = 1'b1;
        tick();
        chk("rel_rdy0", 32'(bus.s0_ready), 1);
        chk("rel_rdy1", 32'(bus.s1_ready), 1);

        push0(32'd5);
        push0(-32'sd7);
        push0(32'd9);
        chk("lv0_3", 32'(bus.level0), 3);
        rd(2'b01, 32'd5, "rd_5");
        chk("lv0_2", 32'(bus.level0), 2);
        rd(2'b01, -32'sd7, "rd_m7");
        chk("lv0_1", 32'(bus.level0), 1);
        rd(2'b01, 32'd9, "rd_9");
        chk("lv0_0", 32'(bus.level0), 0);
        chk("hold_9", bus.io_in, 32'd9);

        rd(2'b01, 32'd9, "uf_io");
        chk("uf_set", 32'(bus.underflow), 32'b01);
        chk("uf_lv0", 32'(bus.level0), 0);
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        chk("uf_clr", 32'(bus.underflow), 0);
        bus.clr_flags = 1'b1;
        rd(2'b01, 32'd9, "sw_io");
        bus.clr_flags = 1'b0;
        chk("set_wins", 32'(bus.underflow), 32'b01);
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        chk("uf_clr2", 32'(bus.underflow), 0);

        bus.s1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.s1_data = 32'(100 + i);
            tick();
        end
        chk("lv1_8", 32'(bus.level1), 8);
        chk("full_rdy", 32'(bus.s1_ready), 0);
        bus.s1_data = 32'd999;
        tick();
        bus.s1_valid = 1'b0;
        chk("full_ign", 32'(bus.level1), 8);
        rd(2'b10, 32'd100, "rd_100");
        chk("rdy_back", 32'(bus.s1_ready), 1);
        chk("lv1_7", 32'(bus.level1), 7);
        for (int i = 1; i < 8; i++) begin
            rd(2'b10, 32'(100 + i), "rd_ch1");
        end
        chk("lv1_0", 32'(bus.level1), 0);
        chk("ch1_uf", 32'(bus.underflow), 0);

        bus.s0_data  = 32'd42;
        bus.s0_valid = 1'b1;
        rd(2'b01, 32'd107, "pp_io");
        bus.s0_valid = 1'b0;
        chk("pp_uf", 32'(bus.underflow), 32'b01);
        chk("pp_lv0", 32'(bus.level0), 1);
        rd(2'b01, 32'd42, "rd_42");
        chk("pp_lv0b", 32'(bus.level0), 0);
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;

        bus.s0_data  = 32'd1;
        bus.s0_valid = 1'b1;
        bus.s1_data  = 32'd2;
        bus.s1_valid = 1'b1;
        tick();
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        rd(2'b11, 32'd1, "ill_io");
        chk("ill_lv0", 32'(bus.level0), 0);
        chk("ill_lv1", 32'(bus.level1), 1);
        chk("ill_err", 32'(bus.req_err), 1);
        chk("ill_uf", 32'(bus.underflow), 0);

        bus.s1_data  = 32'd3;
        bus.s1_valid = 1'b1;
        tick();
        bus.s1_valid = 1'b0;
        chk("pre_lv1", 32'(bus.level1), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_lv1", 32'(bus.level1), 0);
        chk("mid_rdy", 32'(bus.s1_ready), 0);
        chk("mid_io", bus.io_in, 0);
        chk("mid_err", 32'(bus.req_err), 0);
        tick();
        rst = 1'b1;
        tick();
        rd(2'b10, 32'd0, "post_io");
        chk("post_uf", 32'(bus.underflow), 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
